// File: rtl/trace_pkg.sv
// Shared definitions for the processor trace recorder: FSM state encodings,
// capture mode constants and the stored-entry width helper.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // Entry layout, MSB to LSB: {timestamp, valid mask, channel data}
  function automatic int unsigned entry_w(input int unsigned ts_w,
                                          input int unsigned num_ch,
                                          input int unsigned data_w);
    return ts_w + num_ch + num_ch * data_w;
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: DEPTH x WIDTH register array with one synchronous
// write port and one asynchronous read port. Storage is deliberately unreset.
module trace_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_trace_buffer.sv
// On-chip datapath trace recorder: captures timestamped probe-channel samples
// after an immediate or PC-match trigger and drains them first-word fall-through.
module pc_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Arm,
  input  logic                       Clear,
  input  logic                       Mode,
  input  logic                       Trig_En,
  input  logic [DATA_W-1:0]          Trig_PC,
  input  logic                       Stop,
  input  logic [NUM_CH*DATA_W-1:0]   Ch_Data,
  input  logic [NUM_CH-1:0]          Ch_Valid,
  input  logic                       Rd_Ready,
  output logic                       Rd_Valid,
  output logic [TS_W-1:0]            Rd_Ts,
  output logic [NUM_CH-1:0]          Rd_Mask,
  output logic [NUM_CH*DATA_W-1:0]   Rd_Data,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic [1:0]                 State,
  output logic                       Overflow
);

  localparam int unsigned ENTRY_W = entry_w(TS_W, NUM_CH, DATA_W);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic                ovf_q, ovf_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   trig_pc_q, trig_pc_d;

  logic                full, empty, arm_ok, hit, pop, push;
  logic [NUM_CH*DATA_W-1:0] masked_data;
  logic [ENTRY_W-1:0]  wr_entry, rd_entry;

  always_comb begin
    masked_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (Ch_Valid[k]) masked_data[k*DATA_W +: DATA_W] = Ch_Data[k*DATA_W +: DATA_W];
    end
    wr_entry = {ts_q, Ch_Valid, masked_data};
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ts_d      = ts_q + 1'b1;
    ovf_d     = ovf_q;
    mode_d    = mode_q;
    trig_pc_d = trig_pc_q;

    full   = (count_q == FULL_CNT);
    empty  = (count_q == '0);
    arm_ok = Arm & ~Clear & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    hit    = (state_q == ST_ARMED) &
             (~Trig_En | (Ch_Valid[0] & (Ch_Data[DATA_W-1:0] == trig_pc_q)));
    pop    = ~empty & Rd_Ready & ~Clear;
    // A stop-mode buffer that is full only accepts a push when a pop frees a slot
    push   = ((state_q == ST_CAPTURE) | hit) & (|Ch_Valid) & ~Clear &
             ((mode_q == MODE_WRAP) | ~full | pop);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop) begin
      if (full) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        ovf_d    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    unique case (state_q)
      ST_IDLE:    if (arm_ok) state_d = ST_ARMED;
      ST_ARMED:   if (hit) state_d = ST_CAPTURE;
      ST_CAPTURE: if (Stop) state_d = ST_DONE;
      ST_DONE:    if (arm_ok) state_d = ST_ARMED;
      default:    state_d = ST_IDLE;
    endcase

    if (((state_q == ST_CAPTURE) | hit) && (mode_q == MODE_STOP) && (count_d == FULL_CNT))
      state_d = ST_DONE;

    // The arming cycle is timestamp 0, so the first cycle after it reads 1
    if (arm_ok) begin
      ts_d      = TS_W'(1);
      mode_d    = Mode;
      trig_pc_d = Trig_PC;
    end

    if (Clear) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ts_q      <= '0;
      ovf_q     <= 1'b0;
      mode_q    <= 1'b0;
      trig_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ts_q      <= ts_d;
      ovf_q     <= ovf_d;
      mode_q    <= mode_d;
      trig_pc_q <= trig_pc_d;
    end
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (Clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign Rd_Valid = ~empty;
  assign Rd_Ts    = rd_entry[ENTRY_W-1 -: TS_W];
  assign Rd_Mask  = rd_entry[NUM_CH*DATA_W +: NUM_CH];
  assign Rd_Data  = rd_entry[NUM_CH*DATA_W-1:0];
  assign Count    = count_q;
  assign State    = state_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed self-checking bench for pc_trace_buffer: a vector table for the
// stop-mode and PC-trigger flows plus hand sequences for wrap, reset and timestamp wrap.
module tb_pc_trace_buffer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Arm = 1'b0, Clear = 1'b0, Mode = 1'b0, Trig_En = 1'b0, Stop = 1'b0, Rd_Ready = 1'b0;
  logic [31:0] Trig_PC = '0;
  logic [63:0] Ch_Data = '0;
  logic [1:0]  Ch_Valid = '0;

  logic        Rd_Valid, Overflow;
  logic [7:0]  Rd_Ts;
  logic [1:0]  Rd_Mask, State;
  logic [63:0] Rd_Data;
  logic [2:0]  Count;

  logic        Rd_Valid4, Overflow4;
  logic [3:0]  Rd_Ts4;
  logic [1:0]  Rd_Mask4, State4;
  logic [63:0] Rd_Data4;
  logic [2:0]  Count4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pc_trace_buffer #(.DATA_W(32), .NUM_CH(2), .DEPTH(4), .TS_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Arm(Arm), .Clear(Clear), .Mode(Mode), .Trig_En(Trig_En),
    .Trig_PC(Trig_PC), .Stop(Stop), .Ch_Data(Ch_Data), .Ch_Valid(Ch_Valid),
    .Rd_Ready(Rd_Ready), .Rd_Valid(Rd_Valid), .Rd_Ts(Rd_Ts), .Rd_Mask(Rd_Mask),
    .Rd_Data(Rd_Data), .Count(Count), .State(State), .Overflow(Overflow)
  );

  pc_trace_buffer #(.DATA_W(32), .NUM_CH(2), .DEPTH(4), .TS_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Arm(Arm), .Clear(Clear), .Mode(Mode), .Trig_En(Trig_En),
    .Trig_PC(Trig_PC), .Stop(Stop), .Ch_Data(Ch_Data), .Ch_Valid(Ch_Valid),
    .Rd_Ready(Rd_Ready), .Rd_Valid(Rd_Valid4), .Rd_Ts(Rd_Ts4), .Rd_Mask(Rd_Mask4),
    .Rd_Data(Rd_Data4), .Count(Count4), .State(State4), .Overflow(Overflow4)
  );

  typedef struct {
    logic        arm, clr, mode, ten;
    logic [31:0] tpc;
    logic        stop;
    logic [31:0] d0, d1;
    logic [1:0]  vld;
    logic        rdy;
    logic [1:0]  st;
    logic [2:0]  cnt;
    logic        rv, ovf;
    logic [7:0]  ts;
    logic [1:0]  msk;
    logic [31:0] h0, h1;
  } vec_t;

  vec_t vec [20];

  function automatic vec_t mk(input logic arm, clr, mode, ten, input logic [31:0] tpc,
                              input logic stop, input logic [31:0] d0, d1,
                              input logic [1:0] vld, input logic rdy,
                              input logic [1:0] st, input logic [2:0] cnt,
                              input logic rv, ovf, input logic [7:0] ts,
                              input logic [1:0] msk, input logic [31:0] h0, h1);
    vec_t v;
    v.arm = arm; v.clr = clr; v.mode = mode; v.ten = ten; v.tpc = tpc; v.stop = stop;
    v.d0 = d0; v.d1 = d1; v.vld = vld; v.rdy = rdy;
    v.st = st; v.cnt = cnt; v.rv = rv; v.ovf = ovf; v.ts = ts; v.msk = msk; v.h0 = h0; v.h1 = h1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input logic arm, clr, mode, ten, input logic [31:0] d0, d1,
                    input logic [1:0] vld, input logic rdy);
    Arm = arm; Clear = clr; Mode = mode; Trig_En = ten; Trig_PC = '0; Stop = 1'b0;
    Ch_Data = {d1, d0}; Ch_Valid = vld; Rd_Ready = rdy;
    cyc();
  endtask

  task automatic idle();
    go(0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask

  initial begin
    // arm clr mode ten tpc stop d0 d1 vld rdy | st cnt rv ovf ts msk h0 h1
    vec[0]  = mk(1,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,0, 2'd1,3'd0,0,0,8'd0,2'b00,32'h0,  32'h0);
    vec[1]  = mk(0,0,0,0,32'h0, 0,32'h100,32'hA0,  2'b11,0, 2'd2,3'd1,1,0,8'd1,2'b11,32'h100,32'hA0);
    vec[2]  = mk(0,0,0,0,32'h0, 0,32'h104,32'hA1,  2'b11,0, 2'd2,3'd2,1,0,8'd1,2'b11,32'h100,32'hA0);
    vec[3]  = mk(0,0,0,0,32'h0, 0,32'h108,32'hA2,  2'b11,0, 2'd2,3'd3,1,0,8'd1,2'b11,32'h100,32'hA0);
    vec[4]  = mk(0,0,0,0,32'h0, 0,32'h10C,32'hA3,  2'b11,0, 2'd3,3'd4,1,0,8'd1,2'b11,32'h100,32'hA0);
    vec[5]  = mk(0,0,0,0,32'h0, 0,32'h110,32'hA4,  2'b11,0, 2'd3,3'd4,1,0,8'd1,2'b11,32'h100,32'hA0);
    vec[6]  = mk(0,0,0,0,32'h0, 0,32'h114,32'hA5,  2'b11,0, 2'd3,3'd4,1,0,8'd1,2'b11,32'h100,32'hA0);
    vec[7]  = mk(0,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,1, 2'd3,3'd3,1,0,8'd2,2'b11,32'h104,32'hA1);
    vec[8]  = mk(0,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,1, 2'd3,3'd2,1,0,8'd3,2'b11,32'h108,32'hA2);
    vec[9]  = mk(0,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,1, 2'd3,3'd1,1,0,8'd4,2'b11,32'h10C,32'hA3);
    vec[10] = mk(0,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,1, 2'd3,3'd0,0,0,8'd0,2'b00,32'h0,  32'h0);
    vec[11] = mk(1,0,0,1,32'h40,0,32'h0,  32'h0,   2'b00,0, 2'd1,3'd0,0,0,8'd0,2'b00,32'h0,  32'h0);
    vec[12] = mk(0,0,0,1,32'h0, 0,32'h30, 32'h1,   2'b11,0, 2'd1,3'd0,0,0,8'd0,2'b00,32'h0,  32'h0);
    vec[13] = mk(0,0,0,1,32'h0, 0,32'h34, 32'h2,   2'b11,0, 2'd1,3'd0,0,0,8'd0,2'b00,32'h0,  32'h0);
    vec[14] = mk(0,0,0,1,32'h0, 0,32'h40, 32'h3,   2'b11,0, 2'd2,3'd1,1,0,8'd3,2'b11,32'h40, 32'h3);
    vec[15] = mk(0,0,0,1,32'h0, 0,32'h44, 32'h4,   2'b11,0, 2'd2,3'd2,1,0,8'd3,2'b11,32'h40, 32'h3);
    vec[16] = mk(0,0,0,1,32'h0, 1,32'h48, 32'hDEAD,2'b01,0, 2'd3,3'd3,1,0,8'd3,2'b11,32'h40, 32'h3);
    vec[17] = mk(0,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,1, 2'd3,3'd2,1,0,8'd4,2'b11,32'h44, 32'h4);
    vec[18] = mk(0,0,0,0,32'h0, 0,32'h0,  32'h0,   2'b00,1, 2'd3,3'd1,1,0,8'd5,2'b01,32'h48, 32'h0);
    vec[19] = mk(0,1,0,0,32'h0, 0,32'h99, 32'h99,  2'b11,1, 2'd0,3'd0,0,0,8'd0,2'b00,32'h0,  32'h0);

    repeat (2) @(posedge Clk);
    #1;
    chk("reset state", State, 2'd0);
    chk("reset count", Count, 3'd0);
    chk("reset rd_valid", Rd_Valid, 1'b0);
    chk("reset overflow", Overflow, 1'b0);
    Rst = 1'b1;
    cyc();

    for (int i = 0; i < 20; i++) begin
      Arm = vec[i].arm; Clear = vec[i].clr; Mode = vec[i].mode; Trig_En = vec[i].ten;
      Trig_PC = vec[i].tpc; Stop = vec[i].stop; Ch_Data = {vec[i].d1, vec[i].d0};
      Ch_Valid = vec[i].vld; Rd_Ready = vec[i].rdy;
      cyc();
      chk($sformatf("v%0d state", i), State, vec[i].st);
      chk($sformatf("v%0d count", i), Count, vec[i].cnt);
      chk($sformatf("v%0d rd_valid", i), Rd_Valid, vec[i].rv);
      chk($sformatf("v%0d overflow", i), Overflow, vec[i].ovf);
      if (vec[i].rv) begin
        chk($sformatf("v%0d rd_ts", i), Rd_Ts, vec[i].ts);
        chk($sformatf("v%0d rd_mask", i), Rd_Mask, vec[i].msk);
        chk($sformatf("v%0d rd_data", i), Rd_Data, {vec[i].h1, vec[i].h0});
      end
    end

    // Wrap mode: 7 pushes into 4 slots, oldest three overwritten
    go(0, 1, 0, 0, 0, 0, 2'b00, 0);
    go(1, 0, 1, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 7; k++) go(0, 0, 0, 0, 32'(k * 4), 32'(k), 2'b11, 0);
    chk("wrap count", Count, 3'd4);
    chk("wrap overflow", Overflow, 1'b1);
    chk("wrap head ts", Rd_Ts, 8'd4);
    for (int k = 0; k < 4; k++) begin
      Ch_Valid = 2'b00;
      chk($sformatf("wrap drain %0d", k), Rd_Data[31:0], 32'(32'hC + k * 4));
      go(0, 0, 0, 0, 0, 0, 2'b00, 1);
    end
    chk("wrap drained", Rd_Valid, 1'b0);

    // Wrap mode, full, simultaneous push and pop
    go(0, 1, 0, 0, 0, 0, 2'b00, 0);
    go(1, 0, 1, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 4; k++) go(0, 0, 0, 0, 32'(32'h200 + k * 4), 0, 2'b11, 0);
    chk("pp full count", Count, 3'd4);
    chk("pp head before", Rd_Data[31:0], 32'h200);
    go(0, 0, 0, 0, 32'h210, 0, 2'b11, 1);
    chk("pp count", Count, 3'd4);
    chk("pp overflow", Overflow, 1'b0);
    chk("pp head after", Rd_Data[31:0], 32'h204);
    repeat (3) go(0, 0, 0, 0, 0, 0, 2'b00, 1);
    chk("pp newest", Rd_Data[31:0], 32'h210);

    // Asynchronous reset in the middle of a capture
    go(0, 1, 0, 0, 0, 0, 2'b00, 0);
    go(1, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 3; k++) go(0, 0, 0, 0, 32'(32'h300 + k * 4), 0, 2'b11, 0);
    chk("areset pre count", Count, 3'd3);
    chk("areset pre state", State, 2'd2);
    Rst = 1'b0;
    #1;
    chk("areset state", State, 2'd0);
    chk("areset count", Count, 3'd0);
    chk("areset rd_valid", Rd_Valid, 1'b0);
    chk("areset overflow", Overflow, 1'b0);
    #1;
    Rst = 1'b1;
    idle();

    // Timestamp wrap on the 4-bit instance: entries at ts 15 and 16 (0 mod 16)
    go(1, 0, 0, 0, 0, 0, 2'b00, 0);
    repeat (14) idle();
    go(0, 0, 0, 0, 32'h500, 0, 2'b01, 0);
    go(0, 0, 0, 0, 32'h504, 0, 2'b01, 0);
    chk("ts8 first", Rd_Ts, 8'd15);
    chk("ts4 first", Rd_Ts4, 4'd15);
    go(0, 0, 0, 0, 0, 0, 2'b00, 1);
    chk("ts8 second", Rd_Ts, 8'd16);
    chk("ts4 wrapped", Rd_Ts4, 4'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
